double_multiplier_arbiter: RTL

Round-robin arbiter that shares one sequential double-precision multiplier between N requesters. Each requester presents an operand pair (a, b) on a stb/ack handshake. The arbiter feeds the pair to the multiplier's a and b ports in turn, collects z, and returns it to the granted requester. Only one operation is in flight at a time, because the multiplier is not pipelined. The arbiter sits between the pair-HMM compute lanes and the single shared multiplier instance.

---
 rtl/double_multiplier_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/double_multiplier_arbiter.sv
// double_multiplier_arbiter
//
// Shares one non-pipelined double-precision multiplier between N requesters.
// A round-robin arbiter takes one operand pair at a time over a stb/ack
// handshake. It feeds a and then b to the multiplier, collects z, and hands z
// back to the requester that owns the operation. Operands and results pass
// through untouched. Every output is a register.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset; the
//                            same rst also resets the shared multiplier
//   in_a, in_b   [N*64]      operand pairs; requester i uses [64i+63:64i]
//   in_stb/in_ack [N]        operand handshake per requester
//   out_z        [64]        result bus shared by all requesters
//   out_stb/out_ack [N]      result handshake per requester
//   mul_a, mul_a_stb/ack     operand a channel to the multiplier
//   mul_b, mul_b_stb/ack     operand b channel to the multiplier
//   mul_z, mul_z_stb/ack     result channel from the multiplier
//   busy                     high whenever an operation is in progress
//   grant_id     [3]         current or most recently granted requester
module double_multiplier_arbiter #(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*64-1:0] in_a,
    input  logic [N*64-1:0] in_b,
    input  logic [N-1:0]    in_stb,
    output logic [N-1:0]    in_ack,
    output logic [63:0]     out_z,
    output logic [N-1:0]    out_stb,
    input  logic [N-1:0]    out_ack,
    output logic [63:0]     mul_a,
    output logic            mul_a_stb,
    input  logic            mul_a_ack,
    output logic [63:0]     mul_b,
    output logic            mul_b_stb,
    input  logic            mul_b_ack,
    input  logic [63:0]     mul_z,
    input  logic            mul_z_stb,
    output logic            mul_z_ack,
    output logic            busy,
    output logic [2:0]      grant_id
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        ARB,
        ACCEPT,
        SEND_A,
        SEND_B,
        WAIT_Z,
        PUT_Z
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   rr_winner;
    logic [63:0]     op_b;

    // Round-robin search starting just after the last served requester.
    // The loop runs from the farthest offset down to the nearest one, so the
    // nearest requesting index is the value left standing at the end.
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] req,
                                              input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        int            idx;
        pick = last;
        for (int off = N; off >= 1; off--) begin
            idx = (int'(last) + off) % N;
            if (req[GW'(idx)]) begin
                pick = GW'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [GW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign rr_winner = rr_pick(in_stb, last_grant);
    assign grant_id  = 3'(grant);

    // The strobes and acks are registered on entry to their state. Each
    // state's transfer condition therefore only needs the partner signal.
    always_comb begin
        state_next = state;
        unique case (state)
            ARB:     if (|in_stb)        state_next = ACCEPT;
            ACCEPT:  if (in_stb[grant])  state_next = SEND_A;
            SEND_A:  if (mul_a_ack)      state_next = SEND_B;
            SEND_B:  if (mul_b_ack)      state_next = WAIT_Z;
            WAIT_Z:  if (mul_z_stb)      state_next = PUT_Z;
            PUT_Z:   if (out_ack[grant]) state_next = ARB;
            default:                     state_next = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            last_grant <= GW'(N - 1);
            grant      <= '0;
            in_ack     <= '0;
            out_stb    <= '0;
            mul_a_stb  <= 1'b0;
            mul_b_stb  <= 1'b0;
            mul_z_ack  <= 1'b0;
            busy       <= 1'b0;
            out_z      <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ARB);
            case (state)
                ARB: begin
                    if (|in_stb) begin
                        grant  <= rr_winner;
                        in_ack <= onehot(rr_winner);
                    end
                end
                ACCEPT: begin
                    if (in_stb[grant]) begin
                        in_ack    <= '0;
                        mul_a     <= in_a[64*grant +: 64];
                        mul_a_stb <= 1'b1;
                    end
                end
                SEND_A: begin
                    if (mul_a_ack) begin
                        mul_a_stb <= 1'b0;
                        mul_b     <= op_b;
                        mul_b_stb <= 1'b1;
                    end
                end
                SEND_B: begin
                    if (mul_b_ack) begin
                        mul_b_stb <= 1'b0;
                        mul_z_ack <= 1'b1;
                    end
                end
                WAIT_Z: begin
                    if (mul_z_stb) begin
                        mul_z_ack <= 1'b0;
                        out_z     <= mul_z;
                        out_stb   <= onehot(grant);
                    end
                end
                PUT_Z: begin
                    // Only completion moves the pointer, so a served requester
                    // drops to lowest priority for the next search.
                    if (out_ack[grant]) begin
                        out_stb    <= '0;
                        last_grant <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand b waits here while a is in flight. It needs no reset because
    // it is only read after a fresh capture in ACCEPT.
    always_ff @(posedge clk) begin
        if (state == ACCEPT && in_stb[grant]) begin
            op_b <= in_b[64*grant +: 64];
        end
    end

endmodule
